// File: rtl/dram_mux_emu.sv
// Multiplexed-address DRAM model: RAS/CAS access FSM, fast-page mode, CBR refresh, output enable.
// Define DRAM_REFRESH_CHECK_EN to build the per-window refresh-coverage checker behind o_REFRESH_ERR.
module dram_mux_emu #(
  parameter int ROW_BITS       = 8,
  parameter int COL_BITS       = 6,
  parameter int COL_LSB        = 1,
  parameter int DATA_BITS      = 4,
  parameter int REFRESH_WINDOW = 65536
) (
  input  logic                 i_MCLK,
  input  logic                 i_RST,
  input  logic [ROW_BITS-1:0]  i_ADDR,
  input  logic [DATA_BITS-1:0] i_DIN,
  output logic [DATA_BITS-1:0] o_DOUT,
  output logic                 o_DOUT_EN,
  input  logic                 i_RAS_n,
  input  logic                 i_CAS_n,
  input  logic                 i_WR_n,
  input  logic                 i_RD_n,
  output logic [ROW_BITS-1:0]  o_REFRESH_ROW,
  output logic                 o_REFRESH_ERR
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  if (REFRESH_WINDOW < 1 || COL_BITS + COL_LSB > ROW_BITS) begin : g_bad_params
    $error("dram_mux_emu: column field or refresh window out of range");
  end

  typedef enum logic [1:0] {IDLE, ROW_OPEN, COL_ACTIVE, CBR} state_t;

  state_t               state;
  logic                 prev_ras;
  logic                 prev_cas;
  logic [ROW_BITS-1:0]  row;
  logic [COL_BITS-1:0]  col;
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic                 ras_fall;
  logic                 ras_rise;
  logic                 cas_fall;
  logic                 cas_rise;
  logic [COL_BITS-1:0]  addr_col;
  logic                 row_latch;
  logic                 cbr_entry;
  logic                 early_wr;
  logic                 wr_en;
  logic                 rd_en;
  logic [COL_BITS-1:0]  wr_col;

  // A RAS rise cancels any CAS edge seen in the same sample, so it blocks the early write.
  always_comb begin
    ras_fall  = ~i_RAS_n & prev_ras;
    ras_rise  = i_RAS_n & ~prev_ras;
    cas_fall  = ~i_CAS_n & prev_cas;
    cas_rise  = i_CAS_n & ~prev_cas;
    addr_col  = i_ADDR[COL_LSB +: COL_BITS];
    row_latch = (state == IDLE) && ras_fall && i_CAS_n;
    cbr_entry = (state == IDLE) && ras_fall && !i_CAS_n;
    early_wr  = (state == ROW_OPEN) && cas_fall && !ras_rise;
    wr_en     = !i_WR_n && (early_wr || (state == COL_ACTIVE));
    wr_col    = early_wr ? addr_col : col;
    rd_en     = (state == COL_ACTIVE) && !i_RD_n && i_WR_n;
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state         <= IDLE;
      prev_ras      <= 1'b1;
      prev_cas      <= 1'b1;
      row           <= '0;
      col           <= '0;
      o_DOUT        <= '0;
      o_DOUT_EN     <= 1'b0;
      o_REFRESH_ROW <= '0;
    end else begin
      prev_ras <= i_RAS_n;
      prev_cas <= i_CAS_n;

      if (rd_en) begin
        o_DOUT    <= mem[{col, row}];
        o_DOUT_EN <= 1'b1;
      end else begin
        o_DOUT_EN <= 1'b0;
      end

      if (ras_rise) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (row_latch) begin
              row   <= i_ADDR;
              state <= ROW_OPEN;
            end else if (cbr_entry) begin
              o_REFRESH_ROW <= o_REFRESH_ROW + 1'b1;
              state         <= CBR;
            end
          end
          ROW_OPEN: begin
            if (cas_fall) begin
              col   <= addr_col;
              state <= COL_ACTIVE;
            end
          end
          COL_ACTIVE: begin
            if (cas_rise) state <= ROW_OPEN;
          end
          CBR:     state <= CBR;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Array contents survive reset, like real DRAM cells.
  always_ff @(posedge i_MCLK) begin
    if (wr_en) mem[{wr_col, row}] <= i_DIN;
  end

`ifdef DRAM_REFRESH_CHECK_EN
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int WIN_BITS = $clog2(REFRESH_WINDOW + 1);
  localparam logic [WIN_BITS-1:0] WIN_LAST = WIN_BITS'(REFRESH_WINDOW - 1);

  logic [ROWS-1:0]     touched;
  logic [ROWS-1:0]     touched_next;
  logic [WIN_BITS-1:0] win_cnt;

  // Rows touched in the window's final cycle still count toward that window.
  always_comb begin
    touched_next = touched;
    if (row_latch) touched_next[i_ADDR] = 1'b1;
    if (cbr_entry) touched_next[o_REFRESH_ROW] = 1'b1;
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      touched       <= '0;
      win_cnt       <= '0;
      o_REFRESH_ERR <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      if (!(&touched_next)) o_REFRESH_ERR <= 1'b1;
      touched <= '0;
      win_cnt <= '0;
    end else begin
      touched <= touched_next;
      win_cnt <= win_cnt + 1'b1;
    end
  end
`else
  assign o_REFRESH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dram_mux_emu.sv
// Self-checking bench for dram_mux_emu: scenario tasks compared against an address-keyed memory model.
module tb_dram_mux_emu;

  localparam int ROW_BITS  = 8;
  localparam int COL_BITS  = 6;
  localparam int COL_LSB   = 1;
  localparam int DATA_BITS = 4;
  localparam int WINDOW    = 1024;
`ifdef DRAM_REFRESH_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic                 i_MCLK = 1'b0;
  logic                 i_RST  = 1'b1;
  logic [ROW_BITS-1:0]  i_ADDR = '0;
  logic [DATA_BITS-1:0] i_DIN  = '0;
  logic                 i_RAS_n = 1'b1;
  logic                 i_CAS_n = 1'b1;
  logic                 i_WR_n  = 1'b1;
  logic                 i_RD_n  = 1'b1;
  logic [DATA_BITS-1:0] o_DOUT;
  logic                 o_DOUT_EN;
  logic [ROW_BITS-1:0]  o_REFRESH_ROW;
  logic                 o_REFRESH_ERR;

  int checks   = 0;
  int failures = 0;
  int refresh_count = 0;
  logic [DATA_BITS-1:0] model_mem [int];

  dram_mux_emu #(
    .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .COL_LSB(COL_LSB),
    .DATA_BITS(DATA_BITS), .REFRESH_WINDOW(WINDOW)
  ) dut (
    .i_MCLK(i_MCLK), .i_RST(i_RST), .i_ADDR(i_ADDR), .i_DIN(i_DIN),
    .o_DOUT(o_DOUT), .o_DOUT_EN(o_DOUT_EN), .i_RAS_n(i_RAS_n), .i_CAS_n(i_CAS_n),
    .i_WR_n(i_WR_n), .i_RD_n(i_RD_n), .o_REFRESH_ROW(o_REFRESH_ROW),
    .o_REFRESH_ERR(o_REFRESH_ERR)
  );

  always #5 i_MCLK = ~i_MCLK;

  // Array cell index: column taken from the CAS-time address field, row from the RAS-time address.
  function automatic int key_of(input int row, input int cas_addr);
    int c;
    c = (cas_addr / (1 << COL_LSB)) % (1 << COL_BITS);
    return c * (1 << ROW_BITS) + row;
  endfunction

  task automatic step();
    @(posedge i_MCLK);
    #1;
  endtask

  task automatic bus_idle();
    i_RAS_n = 1'b1; i_CAS_n = 1'b1; i_WR_n = 1'b1; i_RD_n = 1'b1;
  endtask

  task automatic open_row(input logic [7:0] r);
    i_RAS_n = 1'b0; i_CAS_n = 1'b1; i_ADDR = r;
    step();
  endtask

  task automatic close_row();
    bus_idle();
    step();
  endtask

  task automatic col_write(input logic [7:0] r, input logic [7:0] a, input logic [3:0] d,
                           input bit late, output logic en_seen);
    en_seen = 1'b0;
    i_CAS_n = 1'b0; i_ADDR = a; i_RD_n = 1'b1;
    if (late) begin
      i_WR_n = 1'b1; i_DIN = 4'($urandom);
    end else begin
      i_WR_n = 1'b0; i_DIN = d;
    end
    step(); en_seen |= o_DOUT_EN;
    if (late) begin
      i_ADDR = 8'($urandom); i_DIN = d; i_WR_n = 1'b0; i_RD_n = 1'b0;
      step(); en_seen |= o_DOUT_EN;
    end
    i_CAS_n = 1'b1; i_WR_n = 1'b1; i_RD_n = 1'b1; i_ADDR = 8'($urandom);
    step(); en_seen |= o_DOUT_EN;
    model_mem[key_of(int'(r), int'(a))] = d;
  endtask

  // en_seq = {at column latch, one cycle later, after CAS rise}
  task automatic col_read(input logic [7:0] a, output logic [3:0] data, output logic [2:0] en_seq);
    i_CAS_n = 1'b0; i_ADDR = a; i_RD_n = 1'b0; i_WR_n = 1'b1;
    step(); en_seq[2] = o_DOUT_EN;
    i_ADDR = 8'($urandom);
    step(); en_seq[1] = o_DOUT_EN; data = o_DOUT;
    i_CAS_n = 1'b1; i_RD_n = 1'b1;
    step(); step(); en_seq[0] = o_DOUT_EN;
  endtask

  task automatic cbr_pulse(output logic en_seen);
    en_seen = 1'b0;
    i_CAS_n = 1'b0; i_WR_n = 1'b0; i_RD_n = 1'b0; i_DIN = 4'($urandom); i_ADDR = 8'($urandom);
    step(); en_seen |= o_DOUT_EN;
    i_RAS_n = 1'b0;
    step(); en_seen |= o_DOUT_EN;
    i_RAS_n = 1'b1;
    step(); en_seen |= o_DOUT_EN;
    bus_idle();
    step(); en_seen |= o_DOUT_EN;
    refresh_count++;
  endtask

  task automatic apply_reset();
    bus_idle();
    i_RST = 1'b1;
    step();
    step();
    i_RST = 1'b0;
    refresh_count = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (10) step();
    checks++;
    if (o_DOUT !== 4'h0) begin failures++; $display("[TB] FAIL reset_dout got=%h exp=%h", o_DOUT, 4'h0); end
    checks++;
    if (o_DOUT_EN !== 1'b0) begin failures++; $display("[TB] FAIL reset_dout_en got=%b exp=0", o_DOUT_EN); end
    checks++;
    if (o_REFRESH_ROW !== 8'h00) begin failures++; $display("[TB] FAIL reset_refresh_row got=%h exp=00", o_REFRESH_ROW); end
    checks++;
    if (o_REFRESH_ERR !== 1'b0) begin failures++; $display("[TB] FAIL reset_refresh_err got=%b exp=0", o_REFRESH_ERR); end
  endtask

  task automatic test_write_read();
    logic en; logic [3:0] d; logic [2:0] seq; logic [3:0] exp_d;
    open_row(8'h5A);
    col_write(8'h5A, 8'h06, 4'hC, 1'b0, en);
    close_row();
    checks++;
    if (en !== 1'b0) begin failures++; $display("[TB] FAIL wr_dout_en got=%b exp=0", en); end
    open_row(8'h5A);
    col_read(8'h06, d, seq);
    close_row();
    exp_d = model_mem[key_of(8'h5A, 8'h06)];
    checks++;
    if (d !== exp_d) begin failures++; $display("[TB] FAIL rd_data got=%h exp=%h", d, exp_d); end
    checks++;
    if (seq !== 3'b010) begin failures++; $display("[TB] FAIL rd_latency got=%b exp=010", seq); end
  endtask

  task automatic test_page_mode();
    logic en; logic en_any; logic [3:0] d; logic [2:0] seq; logic [3:0] exp_d;
    en_any = 1'b0;
    open_row(8'h33);
    for (int c = 1; c <= 3; c++) begin
      col_write(8'h33, 8'(c << COL_LSB), 4'(c), 1'b0, en);
      en_any |= en;
    end
    close_row();
    checks++;
    if (en_any !== 1'b0) begin failures++; $display("[TB] FAIL page_wr_dout_en got=%b exp=0", en_any); end
    open_row(8'h33);
    for (int c = 1; c <= 3; c++) begin
      col_read(8'(c << COL_LSB), d, seq);
      exp_d = model_mem[key_of(8'h33, c << COL_LSB)];
      checks++;
      if (d !== exp_d) begin failures++; $display("[TB] FAIL page_rd_data col=%0d got=%h exp=%h", c, d, exp_d); end
      checks++;
      if (seq !== 3'b010) begin failures++; $display("[TB] FAIL page_rd_en col=%0d got=%b exp=010", c, seq); end
    end
    close_row();
  endtask

  task automatic test_random();
    logic en; logic [3:0] d; logic [2:0] seq; logic [3:0] exp_d;
    logic [7:0] r; logic [7:0] a; int k;
    for (int t = 0; t < 30; t++) begin
      r = 8'($urandom_range(0, 3) * 17);
      open_row(r);
      for (int n = 0; n < $urandom_range(1, 4); n++) begin
        a = 8'(($urandom_range(0, 3) << COL_LSB) | ($urandom & 32'h81));
        k = key_of(int'(r), int'(a));
        if (model_mem.exists(k) && ($urandom_range(0, 1) == 1)) begin
          col_read(a, d, seq);
          exp_d = model_mem[k];
          checks++;
          if (d !== exp_d) begin failures++; $display("[TB] FAIL rand_rd_data row=%h addr=%h got=%h exp=%h", r, a, d, exp_d); end
          checks++;
          if (seq !== 3'b010) begin failures++; $display("[TB] FAIL rand_rd_en row=%h addr=%h got=%b exp=010", r, a, seq); end
        end else begin
          col_write(r, a, 4'($urandom), 1'($urandom), en);
          checks++;
          if (en !== 1'b0) begin failures++; $display("[TB] FAIL rand_wr_dout_en row=%h addr=%h got=%b exp=0", r, a, en); end
        end
      end
      close_row();
    end
  endtask

  task automatic test_cbr();
    logic en; logic en_any; logic [3:0] d; logic [2:0] seq; logic [3:0] exp_d; logic [7:0] exp_row;
    en_any = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cbr_pulse(en);
      en_any |= en;
      if (i == 0 || i == 100 || i == 255) begin
        exp_row = 8'(refresh_count % 256);
        checks++;
        if (o_REFRESH_ROW !== exp_row) begin failures++; $display("[TB] FAIL cbr_row iter=%0d got=%h exp=%h", i, o_REFRESH_ROW, exp_row); end
      end
    end
    checks++;
    if (en_any !== 1'b0) begin failures++; $display("[TB] FAIL cbr_dout_en got=%b exp=0", en_any); end
    open_row(8'h5A);
    col_read(8'h06, d, seq);
    close_row();
    exp_d = model_mem[key_of(8'h5A, 8'h06)];
    checks++;
    if (d !== exp_d) begin failures++; $display("[TB] FAIL cbr_mem_intact got=%h exp=%h", d, exp_d); end
  endtask

  task automatic test_abort();
    logic en; logic e1; logic e2; logic [3:0] d; logic [2:0] seq; logic [3:0] exp_d;
    open_row(8'h21);
    col_write(8'h21, 8'h0A, 4'h5, 1'b0, en);
    close_row();
    open_row(8'h21);
    i_RAS_n = 1'b1; i_CAS_n = 1'b0; i_ADDR = 8'h0A; i_WR_n = 1'b0; i_RD_n = 1'b0; i_DIN = 4'hA;
    step(); e1 = o_DOUT_EN;
    i_CAS_n = 1'b1; i_WR_n = 1'b1;
    step(); e2 = o_DOUT_EN;
    bus_idle();
    step();
    checks++;
    if ({e1, e2} !== 2'b00) begin failures++; $display("[TB] FAIL abort_dout_en got=%b exp=00", {e1, e2}); end
    open_row(8'h21);
    col_read(8'h0A, d, seq);
    close_row();
    exp_d = model_mem[key_of(8'h21, 8'h0A)];
    checks++;
    if (d !== exp_d) begin failures++; $display("[TB] FAIL abort_no_write got=%h exp=%h", d, exp_d); end
    checks++;
    if (seq !== 3'b010) begin failures++; $display("[TB] FAIL abort_then_read_en got=%b exp=010", seq); end
  endtask

  task automatic test_reset_mid_access();
    logic en; logic [3:0] d; logic [2:0] seq; logic [3:0] exp_d;
    repeat (3) cbr_pulse(en);
    checks++;
    if (o_REFRESH_ROW !== 8'(refresh_count % 256)) begin failures++; $display("[TB] FAIL mid_pre_row got=%h exp=%h", o_REFRESH_ROW, 8'(refresh_count % 256)); end
    open_row(8'h5A);
    i_CAS_n = 1'b0; i_ADDR = 8'h06; i_RD_n = 1'b0; i_WR_n = 1'b1;
    step();
    step();
    checks++;
    if (o_DOUT_EN !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_dout_en got=%b exp=1", o_DOUT_EN); end
    #2;
    i_RST = 1'b1;
    #1;
    checks++;
    if (o_DOUT !== 4'h0) begin failures++; $display("[TB] FAIL mid_rst_dout got=%h exp=0", o_DOUT); end
    checks++;
    if (o_DOUT_EN !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_dout_en got=%b exp=0", o_DOUT_EN); end
    checks++;
    if (o_REFRESH_ROW !== 8'h00) begin failures++; $display("[TB] FAIL mid_rst_row got=%h exp=00", o_REFRESH_ROW); end
    bus_idle();
    step();
    i_RST = 1'b0;
    refresh_count = 0;
    step();
    open_row(8'h5A);
    col_read(8'h06, d, seq);
    close_row();
    exp_d = model_mem[key_of(8'h5A, 8'h06)];
    checks++;
    if (d !== exp_d) begin failures++; $display("[TB] FAIL mid_rst_mem got=%h exp=%h", d, exp_d); end
  endtask

  task automatic test_refresh_full();
    logic [7:0] exp_row;
    apply_reset();
    i_CAS_n = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      i_RAS_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      if (i % 2 == 0) refresh_count++;
      step();
    end
    bus_idle();
    step();
    exp_row = 8'(refresh_count % 256);
    checks++;
    if (o_REFRESH_ROW !== exp_row) begin failures++; $display("[TB] FAIL full_refresh_row got=%h exp=%h", o_REFRESH_ROW, exp_row); end
    checks++;
    if (o_REFRESH_ERR !== 1'b0) begin failures++; $display("[TB] FAIL full_refresh_err got=%b exp=0", o_REFRESH_ERR); end
  endtask

  task automatic test_refresh_partial();
    apply_reset();
    for (int i = 0; i < 1200; i++) begin
      if (i % 2 == 0) begin
        i_RAS_n = 1'b0; i_ADDR = 8'((i / 2) % 255);
      end else begin
        i_RAS_n = 1'b1;
      end
      step();
      if (i == 1000) begin
        checks++;
        if (o_REFRESH_ERR !== 1'b0) begin failures++; $display("[TB] FAIL partial_err_early got=%b exp=0", o_REFRESH_ERR); end
      end
    end
    bus_idle();
    step();
    checks++;
    if (o_REFRESH_ERR !== CHECK_EN) begin failures++; $display("[TB] FAIL partial_err got=%b exp=%b", o_REFRESH_ERR, CHECK_EN); end
  endtask

  initial begin
    $display("[TB] start, refresh checker %s", CHECK_EN ? "enabled" : "disabled");
    test_reset();
    test_write_read();
    test_page_mode();
    test_random();
    test_cbr();
    test_abort();
    test_reset_mid_access();
    test_refresh_full();
    test_refresh_partial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_mux_emu.md
Name: dram_mux_emu

Overview:
- Parametrised multiplexed-address DRAM behavioural model; next generation of the 16k×4 RAS/CAS model.
- Generalised in row/column/data width. Adds:
  - explicit access state machine
  - fast-page mode (multiple CAS cycles per RAS)
  - CAS-before-RAS (CBR) refresh with internal row counter
  - output-enable qualification
- Sits between the video/CPU arbitration logic and the board-level RAM sockets in the core; clocked by the master clock, with sampled (not edge-clocked) RAS/CAS.

Parameters:
- ROW_BITS, 8, row address width; also the width of i_ADDR.
- COL_BITS, 6, column address width; COL_BITS <= ROW_BITS - COL_LSB.
- COL_LSB, 1, lowest i_ADDR bit used as column (column = i_ADDR[COL_LSB +: COL_BITS]).
- DATA_BITS, 4, data word width.
- REFRESH_WINDOW, 65536, MCLK cycles per refresh-check window (optional feature only).

Ports:
- i_MCLK  in  1  master clock; all logic on rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_ADDR  in  ROW_BITS  multiplexed row/column address.
- i_DIN  in  DATA_BITS  write data.
- o_DOUT  out  DATA_BITS  registered read data.
- o_DOUT_EN  out  1  high while o_DOUT carries valid read data (models the DRAM driving the bus).
- i_RAS_n  in  1  row strobe, active low.
- i_CAS_n  in  1  column strobe, active low.
- i_WR_n  in  1  write enable, active low.
- i_RD_n  in  1  read/output enable, active low.
- o_REFRESH_ROW  out  ROW_BITS  internal CBR refresh counter.
- o_REFRESH_ERR  out  1  refresh violation flag (0 when feature compiled out).

Behaviour:
- Storage: 2^(ROW_BITS+COL_BITS) words × DATA_BITS; address = {col, row}. Contents are not reset.
- Strobe edge detection:
  - prev_ras and prev_cas are registered each cycle; reset value 1.
  - Fall = current 0 while prev 1. Rise = current 1 while prev 0.
- Reset values: o_DOUT=0, o_DOUT_EN=0, o_REFRESH_ROW=0, o_REFRESH_ERR=0, state=IDLE, row/col latches=0. Reset mid-access aborts it immediately, with no write.
- States: IDLE, ROW_OPEN, COL_ACTIVE, CBR.
  - IDLE, RAS fall, CAS high → latch row=i_ADDR → ROW_OPEN.
  - IDLE, RAS fall, CAS low or CAS falling in the same sample → CBR; o_REFRESH_ROW increments (wraps 2^ROW_BITS-1 → 0); no array access.
  - ROW_OPEN, CAS fall → latch column → COL_ACTIVE.
  - COL_ACTIVE, CAS rise → ROW_OPEN (page mode). The next CAS fall latches a new column; the row is unchanged.
  - Any state, RAS rise → IDLE. This has priority over a simultaneous CAS edge.
  - CBR exits only on RAS rise. CAS activity inside CBR is ignored.
  - CAS fall in IDLE while RAS high is ignored; state stays IDLE.
- Write:
  - Occurs in any cycle where i_WR_n=0 and either (state=ROW_OPEN with a CAS fall) or state=COL_ACTIVE.
  - Writes i_DIN to {column, row}. The column is the one being latched this cycle (early write) or the held column (late write).
  - One write per cycle; repeated cycles rewrite the same address.
- Read:
  - In any cycle where state=COL_ACTIVE, i_RD_n=0 and i_WR_n=1: o_DOUT ← mem[{col,row}] and o_DOUT_EN ← 1.
  - Latency: data appears one cycle after the column-latch edge.
  - o_DOUT_EN ← 0 in all other cycles. o_DOUT holds its last value.
  - Same-cycle read/write conflict: the write wins; o_DOUT_EN=0.
- Address outside the configured column field: bits not in [COL_LSB +: COL_BITS] are ignored.

Optional Feature:
- Macro: DRAM_REFRESH_CHECK_EN.
- Enabled:
  - Keep a 2^ROW_BITS-bit "touched" bitmap.
  - Mark a row on every RAS fall (row latch), or on a CBR entry using the pre-increment counter value.
  - A window counter counts REFRESH_WINDOW cycles. At the last cycle of the window: if any bit is clear, o_REFRESH_ERR ← 1 (sticky until i_RST). Then clear the bitmap and counter.
- Disabled: no bitmap or counter is generated; o_REFRESH_ERR is tied 0.

Test Plan:
- Reset then idle 10 cycles → o_DOUT=0, o_DOUT_EN=0, o_REFRESH_ROW=0.
- Write then read back: RAS fall with ADDR=0x5A; CAS fall with ADDR=0x06 (col=3); WR_n=0, DIN=0xC. Then a new RAS/CAS to the same address with RD_n=0. → o_DOUT=0xC, o_DOUT_EN=1 exactly one cycle after the CAS-fall sample.
- Page mode: one RAS, three CAS pulses, columns 1/2/3, writing 0x1/0x2/0x3; re-read the same page → 0x1, 0x2, 0x3 in order, with o_DOUT_EN low between CAS pulses.
- CBR: CAS low, then RAS fall, repeated 256 times → o_REFRESH_ROW wraps back to 0; array contents unchanged; o_DOUT_EN stays 0.
- Abort: RAS rise in the same sample as a CAS fall → state IDLE, no write, no read. Assert i_RST mid-COL_ACTIVE → outputs return to their reset values asynchronously.
- With DRAM_REFRESH_CHECK_EN and REFRESH_WINDOW=1024: refresh only rows 0–254 → o_REFRESH_ERR=1 after cycle 1024. Refresh all 256 rows per window → stays 0.
